// File: rtl/fifo_sync_thresh.sv
// fifo_sync_thresh: single-clock FIFO with occupancy count, programmable thresholds, sticky errors and optional FWFT read
module fifo_sync_thresh #(
    parameter int WIDTH  = 8,
    parameter int W_ADDR = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  data_in,
    input  logic              pop,
    output logic [WIDTH-1:0]  data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [W_ADDR:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);
    localparam int DEPTH = 1 << W_ADDR;
    localparam logic [W_ADDR:0] FULL_C = {1'b1, {W_ADDR{1'b0}}};
    localparam logic [W_ADDR:0] AF_C = AF_LVL[W_ADDR:0];
    localparam logic [W_ADDR:0] AE_C = AE_LVL[W_ADDR:0];

    if (AF_LVL < 1 || AF_LVL > DEPTH || AE_LVL < 0 || AE_LVL >= DEPTH) begin : g_bad_param
        $error("fifo_sync_thresh: illegal AF_LVL/AE_LVL for DEPTH");
    end

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [W_ADDR-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [W_ADDR:0]   cnt_nxt;
    logic [WIDTH-1:0]  head, dout_nxt;
    logic              wr_en, rd_en;

    assign rd_en = pop & ~empty;
    assign wr_en = push & (~full | rd_en);
    assign rd_nxt = rd_en ? rd_ptr + 1'b1 : rd_ptr;
    assign cnt_nxt = (wr_en & ~rd_en) ? count + 1'b1 :
                     (rd_en & ~wr_en) ? count - 1'b1 : count;

    assign full         = count == FULL_C;
    assign empty        = count == '0;
    assign almost_full  = count >= AF_C;
    assign almost_empty = count <= AE_C;

    // FWFT head for next cycle; bypass when the new word lands at the next read slot
    assign head = (wr_en && wr_ptr == rd_nxt) ? data_in : mem[rd_nxt];
    assign dout_nxt = (FWFT != 0) ? ((cnt_nxt != '0) ? head : data_out)
                                  : (rd_en ? mem[rd_ptr] : data_out);

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            data_out  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr    <= rd_nxt;
            count     <= cnt_nxt;
            overflow  <= (overflow & ~clr_err) | (push & full & ~rd_en);
            underflow <= (underflow & ~clr_err) | (pop & empty);
            data_out  <= dout_nxt;
        end
    end
endmodule

// File: tb/tb_fifo_sync_thresh.sv
// tb_fifo_sync_thresh: directed bench; standard and FWFT instances checked each cycle against a queue model
module tb_fifo_sync_thresh;
    logic       clk = 1'b0;
    logic       rst_n, push, pop, clr_err;
    logic [7:0] data_in;
    logic [7:0] s_dout, f_dout;
    logic [4:0] s_count, f_count;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] q[$];
    bit         m_ovf, m_unf;
    logic [7:0] m_dstd, m_dfw;

    always #5 clk = ~clk;

    fifo_sync_thresh #(.FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .push(push), .data_in(data_in), .pop(pop),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf),
        .clr_err(clr_err)
    );

    fifo_sync_thresh #(.FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .push(push), .data_in(data_in), .pop(pop),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf),
        .clr_err(clr_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        int n = q.size();
        chk("count", 32'(s_count), 32'(n));
        chk("full", 32'(s_full), 32'(n == 16));
        chk("empty", 32'(s_empty), 32'(n == 0));
        chk("almost_full", 32'(s_af), 32'(n >= 12));
        chk("almost_empty", 32'(s_ae), 32'(n <= 2));
        chk("overflow", 32'(s_ovf), 32'(m_ovf));
        chk("underflow", 32'(s_unf), 32'(m_unf));
        chk("data_out_std", 32'(s_dout), 32'(m_dstd));
        chk("data_out_fwft", 32'(f_dout), 32'(m_dfw));
        chk("fwft_count", 32'(f_count), 32'(n));
        chk("fwft_flags", {26'd0, f_full, f_empty, f_af, f_ae, f_ovf, f_unf},
            {26'd0, n == 16, n == 0, n >= 12, n <= 2, m_ovf, m_unf});
    endtask

    // One clock: drive, let the DUTs and the model advance, then compare away from the edge
    task automatic step(input bit p, input logic [7:0] d, input bit r, input bit c, input bit rn);
        bit pop_ok, push_ok;
        push = p; data_in = d; pop = r; clr_err = c; rst_n = rn;
        @(posedge clk);
        if (!rn) begin
            q.delete();
            m_ovf = 0; m_unf = 0; m_dstd = 8'h00; m_dfw = 8'h00;
        end else begin
            pop_ok  = r && q.size() > 0;
            push_ok = p && (q.size() < 16 || pop_ok);
            m_ovf = (m_ovf && !c) || (p && q.size() == 16 && !pop_ok);
            m_unf = (m_unf && !c) || (r && q.size() == 0);
            if (pop_ok) m_dstd = q.pop_front();
            if (push_ok) q.push_back(d);
            if (q.size() > 0) m_dfw = q[0];
        end
        @(negedge clk);
        compare();
    endtask

    initial begin
        m_ovf = 0; m_unf = 0; m_dstd = 8'h00; m_dfw = 8'h00;
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("rst_count", 32'(s_count), 32'd0);
        chk("rst_empty_ae", {30'd0, s_empty, s_ae}, 32'h3);
        chk("rst_dout", 32'(s_dout), 32'h00);

        // 1: fill then drain in order
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 1);
        chk("t1_full", 32'(s_full), 32'd1);
        chk("t1_count", 32'(s_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 1);
            chk("t1_pop", 32'(s_dout), 32'(i));
        end
        chk("t1_empty", 32'(s_empty), 32'd1);

        // 2: overflow, clear, dropped word never read
        for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 1);
        step(1, 8'hAA, 0, 0, 1);
        chk("t2_ovf", 32'(s_ovf), 32'd1);
        chk("t2_count", 32'(s_count), 32'd16);
        step(0, 8'h00, 0, 1, 1);
        chk("t2_clr", 32'(s_ovf), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 1);
            chk("t2_pop", 32'(s_dout), 32'(8'h10 + i));
        end

        // 3: underflow, push+pop on empty, set wins over clear
        step(0, 8'h00, 1, 0, 1);
        chk("t3_unf", 32'(s_unf), 32'd1);
        chk("t3_hold", 32'(s_dout), 32'h1F);
        step(0, 8'h00, 0, 1, 1);
        step(1, 8'h55, 1, 0, 1);
        chk("t3_count", 32'(s_count), 32'd1);
        chk("t3_unf2", 32'(s_unf), 32'd1);
        chk("t3_fwft", 32'(f_dout), 32'h55);
        step(0, 8'h00, 1, 1, 1);
        chk("t3_read", 32'(s_dout), 32'h55);
        chk("t3_clr", 32'(s_unf), 32'd0);
        step(0, 8'h00, 1, 1, 1);
        chk("t3_setwins", 32'(s_unf), 32'd1);
        step(0, 8'h00, 0, 1, 1);

        // 4: push+pop on full
        for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 0, 1);
        step(1, 8'h77, 1, 0, 1);
        chk("t4_count", 32'(s_count), 32'd16);
        chk("t4_head", 32'(s_dout), 32'h20);
        chk("t4_ovf", 32'(s_ovf), 32'd0);
        for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 1);
        chk("t4_last", 32'(s_dout), 32'h77);

        // 5: threshold sweep up and down
        for (int n = 1; n <= 16; n++) begin
            step(1, 8'(8'h30 + n), 0, 0, 1);
            if (n == 2)  chk("t5_ae_up2", 32'(s_ae), 32'd1);
            if (n == 3)  chk("t5_ae_up3", 32'(s_ae), 32'd0);
            if (n == 11) chk("t5_af_up11", 32'(s_af), 32'd0);
            if (n == 12) chk("t5_af_up12", 32'(s_af), 32'd1);
        end
        for (int n = 15; n >= 0; n--) begin
            step(0, 8'h00, 1, 0, 1);
            if (n == 12) chk("t5_af_dn12", 32'(s_af), 32'd1);
            if (n == 11) chk("t5_af_dn11", 32'(s_af), 32'd0);
            if (n == 3)  chk("t5_ae_dn3", 32'(s_ae), 32'd0);
            if (n == 2)  chk("t5_ae_dn2", 32'(s_ae), 32'd1);
        end
        // pointer wrap with interleaved pops
        for (int i = 0; i < 40; i++) step(1, 8'(8'h80 + i), i % 3 != 0, 0, 1);
        while (q.size() > 0) step(0, 8'h00, 1, 0, 1);
        chk("t5_wrap_last", 32'(s_dout), 32'hA7);

        // 6: FWFT fall-through, consume, mid-stream reset
        step(1, 8'h3C, 0, 0, 1);
        chk("t6_fall", 32'(f_dout), 32'h3C);
        step(1, 8'h3D, 0, 0, 1);
        chk("t6_stay", 32'(f_dout), 32'h3C);
        step(0, 8'h00, 1, 0, 1);
        chk("t6_next", 32'(f_dout), 32'h3D);
        step(1, 8'h3E, 0, 0, 1);
        step(1, 8'h3F, 0, 0, 0);
        chk("t6_rst_count", 32'(f_count), 32'd0);
        chk("t6_rst_empty", 32'(f_empty), 32'd1);
        chk("t6_rst_dout", 32'(f_dout), 32'h00);
        step(0, 8'h00, 1, 0, 1);
        chk("t6_post_unf", 32'(s_unf), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
